data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the MEM stage: IDLE/BUSY/DONE handshake.
// Optional MEM_RANGE_CHECK_EN adds misalignment/out-of-range fault detection.
module data_mem_responder #(
    parameter int          DEPTH     = 64,
    parameter int          LATENCY   = 3,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic        ready,
    output logic [31:0] mem_result,
    output logic        err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        wr_q;
    logic [31:0] mem [DEPTH];

    logic [31:0]   offset;
    logic [31:0]   word_off;
    logic [AW-1:0] idx;
    logic          fault;
    logic          req;
    logic          finish;

    assign req      = mem_r_en | mem_w_en;
    assign offset   = addr_q - BASE_ADDR;
    assign word_off = offset >> 2;
    assign idx      = word_off[AW-1:0];
    assign finish   = (state == BUSY) && (cnt == 4'd0);

    assign ready = (state == DONE) || ((state == IDLE) && !req);

`ifdef MEM_RANGE_CHECK_EN
    assign fault = (addr_q[1:0] != 2'b00) ||
                   (addr_q < BASE_ADDR) ||
                   (word_off >= 32'(DEPTH));

    // err is visible only while the faulting access sits in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (finish) begin
            err <= fault;
        end else if (state == DONE) begin
            err <= 1'b0;
        end
    end
`else
    assign fault = 1'b0;
    assign err   = 1'b0;
`endif

    logic unused;
    assign unused = ^{addr_q[1:0], offset[1:0], word_off[31:AW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            wr_q       <= 1'b0;
            mem_result <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= address;
                        data_q <= data;
                        // a write wins when both enables are high
                        wr_q   <= mem_w_en;
                        cnt    <= CNT_INIT;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        if (wr_q) begin
                            if (!fault) begin
                                mem[idx] <= data_q;
                            end
                        end else begin
                            mem_result <= fault ? 32'd0 : mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a queue scoreboard of expected
// completion values (mem_result, err); a second instance covers LATENCY=1.
module tb_data_mem_responder;

    localparam int          LAT  = 3;
    localparam int          DEP  = 64;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] data = 32'd0;
    logic        ready;
    logic [31:0] mem_result;
    logic        err;

    logic        r1 = 1'b0;
    logic        w1 = 1'b0;
    logic [31:0] a1 = 32'd0;
    logic [31:0] d1 = 32'd0;
    logic        ready1;
    logic [31:0] res1;
    logic        err1;

    int passed = 0;
    int total  = 0;

    logic [31:0] mdl [DEP];
    logic [31:0] last_rd;
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH    (DEP),
        .LATENCY  (LAT),
        .BASE_ADDR(BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .address   (address),
        .data      (data),
        .ready     (ready),
        .mem_result(mem_result),
        .err       (err)
    );

    data_mem_responder #(
        .DEPTH    (DEP),
        .LATENCY  (1),
        .BASE_ADDR(BASE)
    ) dut_lat1 (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (r1),
        .mem_w_en  (w1),
        .address   (a1),
        .data      (d1),
        .ready     (ready1),
        .mem_result(res1),
        .err       (err1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic bit fault_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= 32'(DEP));
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off % 32'(DEP));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEP; i++) mdl[i] = 32'd0;
        last_rd = 32'd0;
        exp_q.delete();
    endtask

    // Drives one request, scoreboards the outcome, waits for DONE and compares.
    task automatic access(input string tag, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
        bit   f;
        int   n;
        exp_t e;
        f = CHK && fault_of(a);
        if (w) begin
            if (!f) mdl[idx_of(a)] = d;
        end else if (r) begin
            last_rd = f ? 32'd0 : mdl[idx_of(a)];
        end
        exp_q.push_back('{res: last_rd, err: f});
        @(negedge clk);
        mem_r_en = r;
        mem_w_en = w;
        address  = a;
        data     = d;
        #1;
        check({tag, "_ready_c0"}, 32'(ready), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
        check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        e = exp_q.pop_front();
        check({tag, "_result"}, mem_result, e.res);
        check({tag, "_err"}, 32'(err), 32'(e.err));
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        int n;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_result", mem_result, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready_l1", 32'(ready1), 32'd1);

        access("wr_beef", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        access("rd_beef", 1'b1, 1'b0, 32'd1024, 32'd0);
        access("wr_5", 1'b0, 1'b1, 32'd1028, 32'd5);
        access("rd_5", 1'b1, 1'b0, 32'd1028, 32'd0);
        access("both_7", 1'b1, 1'b1, 32'd1032, 32'd7);
        access("rd_7", 1'b1, 1'b0, 32'd1032, 32'd0);
        access("wr_top", 1'b0, 1'b1, BASE + 32'd252, 32'hA5A5_5A5A);
        access("rd_top", 1'b1, 1'b0, BASE + 32'd252, 32'd0);

        // reset in the middle of a write
        @(negedge clk);
        mem_w_en = 1'b1;
        address  = 32'd1036;
        data     = 32'd9;
        @(negedge clk);
        check("mid_busy", 32'(ready), 32'd0);
        rst      = 1'b1;
        mem_w_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        check("mid_ready", 32'(ready), 32'd1);
        check("mid_result", mem_result, 32'd0);
        access("rd_1036", 1'b1, 1'b0, 32'd1036, 32'd0);
        access("rd_clr", 1'b1, 1'b0, 32'd1032, 32'd0);

        access("wr_w0", 1'b0, 1'b1, 32'd1024, 32'h11);
        access("wr_mis", 1'b0, 1'b1, 32'd1026, 32'd3);
        access("rd_w0a", 1'b1, 1'b0, 32'd1024, 32'd0);
        access("wr_wrap", 1'b0, 1'b1, BASE + 32'd256, 32'd4);
        access("rd_w0b", 1'b1, 1'b0, 32'd1024, 32'd0);
        access("rd_low", 1'b1, 1'b0, 32'd1020, 32'd0);

        // LATENCY=1 instance: write then read
        @(negedge clk);
        w1 = 1'b1;
        a1 = 32'd1040;
        d1 = 32'h1234_5678;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready1 && n < 40);
        check("l1_wr_latency", 32'(n), 32'd2);
        w1 = 1'b0;
        @(negedge clk);
        r1 = 1'b1;
        #1;
        check("l1_ready_c0", 32'(ready1), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready1 && n < 40);
        check("l1_rd_latency", 32'(n), 32'd2);
        check("l1_result", res1, 32'h1234_5678);
        r1 = 1'b0;

        if (exp_q.size() != 0) begin
            check("sb_empty", 32'(exp_q.size()), 32'd0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
